ledr_pwm_driver: RTL and testbench

LEDR_PWM_DRIVER -- requirements
Module: ledr_pwm_driver

---
 rtl/ledr_drv_pkg.sv | 24 ++
 rtl/ledr_tick_gen.sv | 38 +++
 rtl/ledr_pwm_driver.sv | 128 ++++++++++++
 tb/tb_ledr_pwm_driver.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledr_drv_pkg.sv
// Shared definitions for the LEDR PWM driver: Avalon-MM register addresses,
// CTRL bit positions and register reset values.
package ledr_drv_pkg;

  // Avalon-MM word addresses of the register file.
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DUTY   = 2'd1,
    REG_PERIOD = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  // CTRL register bit indices.
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_BLINK_BIT  = 1;

  // Reset values.
  localparam logic        RST_ENABLE      = 1'b1;
  localparam logic        RST_BLINK_EN    = 1'b0;
  localparam logic [7:0]  RST_DUTY        = 8'hFF;
  localparam logic [15:0] RST_PERIOD      = 16'h0000;
  localparam logic        RST_BLINK_PHASE = 1'b1;

endpackage

// File: rtl/ledr_tick_gen.sv
// Prescaler and 8-bit PWM counter for the LEDR driver.
//   clk       : system clock (rising edge)
//   reset_n   : asynchronous active-low reset
//   tick      : one-cycle strobe every PRESCALE clocks
//   frame_end : tick on the last step of a PWM frame (pwm_cnt == 255)
//   pwm_cnt   : current PWM phase, advances on tick, wraps 255 -> 0
module ledr_tick_gen #(
  parameter int unsigned PRESCALE = 195
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       tick,
  output logic       frame_end,
  output logic [7:0] pwm_cnt
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ledr_pwm_driver.sv
// PWM dimming and blink driver for the board LEDs, with an Avalon-MM slave
// register file (CTRL, DUTY, PERIOD, STATUS).
//   clk, reset_n : system clock, asynchronous active-low reset
//   led_pattern  : LED pattern from the LEDR PIO
//   address, chipselect, write_n, writedata, readdata : Avalon-MM slave,
//                  zero wait-state combinational read
//   ledr         : registered LED drive
module ledr_pwm_driver
  import ledr_drv_pkg::*;
#(
  parameter int unsigned PRESCALE = 195,
  parameter int unsigned NUM_LED  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_LED-1:0] led_pattern,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [NUM_LED-1:0] ledr
);

  logic        enable;
  logic        blink_en;
  logic [7:0]  duty;
  logic [15:0] period;
  logic [15:0] blink_cnt;
  logic        blink_phase;

  logic        tick;
  logic        frame_end;
  logic [7:0]  pwm_cnt;

  logic        wr;
  logic        wr_period;
  logic        pwm_on;
  logic        led_gate;
  reg_addr_e   reg_addr;

  // Upper write-data bits and the raw tick are intentionally not consumed.
  logic        unused_bits;
  assign unused_bits = ^{writedata[31:16], tick};

  ledr_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .frame_end(frame_end),
    .pwm_cnt  (pwm_cnt)
  );

  assign reg_addr  = reg_addr_e'(address);
  assign wr        = chipselect && !write_n;
  assign wr_period = wr && (reg_addr == REG_PERIOD);
  assign pwm_on    = (pwm_cnt < duty);
  assign led_gate  = enable && pwm_on && blink_phase;

  // Register file; STATUS is read-only so writes to it fall through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= RST_ENABLE;
      blink_en <= RST_BLINK_EN;
      duty     <= RST_DUTY;
      period   <= RST_PERIOD;
    end else if (wr) begin
      case (reg_addr)
        REG_CTRL: begin
          enable   <= writedata[CTRL_ENABLE_BIT];
          blink_en <= writedata[CTRL_BLINK_BIT];
        end
        REG_DUTY:   duty   <= writedata[7:0];
        REG_PERIOD: period <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Blink counter; a PERIOD write restarts the blink cycle and wins over a
  // coincident frame_end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= RST_BLINK_PHASE;
    end else if (wr_period || !blink_en || (period == '0)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == period - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr <= '0;
    end else begin
      ledr <= led_gate ? led_pattern : '0;
    end
  end

  // Combinational read mux, unused bits zero.
  always_comb begin
    readdata = '0;
    case (reg_addr)
      REG_CTRL: begin
        readdata[CTRL_ENABLE_BIT] = enable;
        readdata[CTRL_BLINK_BIT]  = blink_en;
      end
      REG_DUTY:   readdata[7:0]  = duty;
      REG_PERIOD: readdata[15:0] = period;
      REG_STATUS: begin
        readdata[0]    = blink_phase;
        readdata[15:8] = pwm_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Self-checking bench for ledr_pwm_driver. Two instances (PRESCALE 1 and 3)
// share all inputs and are compared every cycle against a frame-arithmetic
// reference model.
module tb_ledr_pwm_driver;

  localparam int unsigned NL = 10;
  localparam int P0 = 1;
  localparam int P1 = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NL-1:0] led_pattern = '0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;

  logic [NL-1:0] ledr0, ledr1;
  logic [31:0]   rd0, rd1;
  logic [NL-1:0] ledr_a [2];
  logic [31:0]   rd_a [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ledr_pwm_driver #(.PRESCALE(P0), .NUM_LED(NL)) dut_p1 (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .ledr(ledr0)
  );

  ledr_pwm_driver #(.PRESCALE(P1), .NUM_LED(NL)) dut_p3 (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .ledr(ledr1)
  );

  always_comb begin
    ledr_a[0] = ledr0;
    ledr_a[1] = ledr1;
    rd_a[0]   = rd0;
    rd_a[1]   = rd1;
  end

  // ---------------- reference model ----------------
  // m_n counts clock edges since reset; pwm phase and frame boundaries follow
  // from integer division. m_frames counts frames since the blink cycle last
  // restarted; the phase is the parity of completed half-periods.
  int            m_n [2] = '{0, 0};
  int            m_frames [2] = '{0, 0};
  logic          m_phase [2] = '{1'b1, 1'b1};
  logic [NL-1:0] m_ledr [2] = '{'0, '0};
  logic          m_enable = 1'b1;
  logic          m_blink_en = 1'b0;
  logic [7:0]    m_duty = 8'hFF;
  int            m_period = 0;

  function automatic int pre_of(int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int pwm_of(int i);
    return (m_n[i] / pre_of(i)) % 256;
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_blink_en, m_enable};
      2'd1:    return {24'd0, m_duty};
      2'd2:    return 32'(m_period);
      default: return {16'd0, 8'(pwm_of(i)), 7'd0, m_phase[i]};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0; m_frames[i] = 0; m_phase[i] = 1'b1; m_ledr[i] = '0;
      end
      m_enable = 1'b1; m_blink_en = 1'b0; m_duty = 8'hFF; m_period = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int pc;
        bit fe;
        pc = pwm_of(i);
        fe = ((m_n[i] + 1) % (256 * pre_of(i))) == 0;
        m_ledr[i] = (m_enable && (pc < int'(m_duty)) && m_phase[i]) ? led_pattern : '0;
        if (chipselect && !write_n && address == 2'd2) begin
          m_frames[i] = 0; m_phase[i] = 1'b1;
        end else if (!m_blink_en || m_period == 0) begin
          m_frames[i] = 0; m_phase[i] = 1'b1;
        end else if (fe) begin
          m_frames[i]++;
          m_phase[i] = ((m_frames[i] / m_period) % 2) == 0;
        end
        m_n[i]++;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: begin m_enable = writedata[0]; m_blink_en = writedata[1]; end
          2'd1: m_duty = writedata[7:0];
          2'd2: m_period = int'(writedata[15:0]);
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rst_vals [4];
    rst_vals = '{32'h1, 32'hFF, 32'h0, 32'h1};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ledr_a[i] !== '0) begin
        errors++; $display("FAIL reset_ledr[%0d]: got %h, expected 0", i, ledr_a[i]);
      end
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_a[i] !== rst_vals[a]) begin
          errors++; $display("FAIL reset_reg%0d[%0d]: got %h, expected %h", a, i, rd_a[i], rst_vals[a]);
        end
      end
    end
    address = 2'd3;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd0[15:8] !== 8'd1 || rd1[15:8] !== 8'd0) begin
      errors++; $display("FAIL reset_release_pwm: got %h/%h, expected 01/00", rd0[15:8], rd1[15:8]);
    end
  endtask

  task automatic test_full_duty();
    int on_cnt = 0;
    led_pattern = 10'h3FF;
    address = 2'd3;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ledr_a[i] !== m_ledr[i]) begin
          errors++; $display("FAIL full_duty_ledr[%0d] @%0t: got %h, expected %h", i, $time, ledr_a[i], m_ledr[i]);
        end
        checks++;
        if (rd_a[i] !== exp_rd(i, address)) begin
          errors++; $display("FAIL full_duty_status[%0d] @%0t: got %h, expected %h", i, $time, rd_a[i], exp_rd(i, address));
        end
      end
      if (c >= 344 && ledr0 == 10'h3FF) on_cnt++;
    end
    checks++;
    if (on_cnt != 255) begin
      errors++; $display("FAIL full_duty_on_count: got %0d, expected 255", on_cnt);
    end
  endtask

  task automatic test_duty();
    int on0 = 0;
    int on1 = 0;
    int nz = 0;
    led_pattern = 10'h155;
    do_write(2'd1, 32'd64);
    address = 2'd3;
    for (int c = 0; c < 780; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ledr_a[i] !== m_ledr[i]) begin
          errors++; $display("FAIL duty64_ledr[%0d] @%0t: got %h, expected %h", i, $time, ledr_a[i], m_ledr[i]);
        end
      end
      if (c >= 10 && c < 522 && ledr0 == 10'h155) on0++;
      if (c >= 10 && ledr1 == 10'h155) on1++;
    end
    checks++;
    if (on0 != 128) begin
      errors++; $display("FAIL duty64_on_p1: got %0d, expected 128", on0);
    end
    checks++;
    if (on1 != 192) begin
      errors++; $display("FAIL duty64_on_p3: got %0d, expected 192", on1);
    end
    do_write(2'd1, 32'd0);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (ledr0 !== '0 || ledr1 !== '0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL duty0_dark: got %0d lit cycles, expected 0", nz);
    end
  endtask

  task automatic test_blink();
    int toggles = 0;
    logic prev;
    led_pattern = 10'h3FF;
    do_write(2'd1, 32'd255);
    do_write(2'd2, 32'd2);
    do_write(2'd0, 32'd3);
    address = 2'd3;
    #1 prev = rd0[0];
    for (int c = 0; c < 3840; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ledr_a[i] !== m_ledr[i]) begin
          errors++; $display("FAIL blink_ledr[%0d] @%0t: got %h, expected %h", i, $time, ledr_a[i], m_ledr[i]);
        end
        checks++;
        if (rd_a[i] !== exp_rd(i, address)) begin
          errors++; $display("FAIL blink_status[%0d] @%0t: got %h, expected %h", i, $time, rd_a[i], exp_rd(i, address));
        end
      end
      if (rd0[0] !== prev) toggles++;
      prev = rd0[0];
    end
    checks++;
    if (toggles < 7 || toggles > 8) begin
      errors++; $display("FAIL blink_toggle_count: got %0d, expected 7..8", toggles);
    end
  endtask

  task automatic test_period_frame_end();
    bit found = 0;
    do_write(2'd0, 32'd3);
    do_write(2'd2, 32'd1);
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (m_phase[0] && (m_n[0] % 256) == 255) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL period_fe_search: got no aligned frame_end, expected one within 3000 cycles");
    end else begin
      do_write(2'd2, 32'd2);
      address = 2'd3;
      #1;
      checks++;
      if (rd0[0] !== 1'b1 || rd0[15:8] !== 8'h00) begin
        errors++; $display("FAIL period_fe_status: got %h, expected phase 1 pwm 00", rd0);
      end
      for (int c = 0; c < 1200; c++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (rd_a[i] !== exp_rd(i, address)) begin
            errors++; $display("FAIL period_fe_follow[%0d] @%0t: got %h, expected %h", i, $time, rd_a[i], exp_rd(i, address));
          end
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [31:0] exp_vals [3];
    exp_vals = '{32'h0, 32'h5A, 32'h9876};
    led_pattern = 10'h2AB;
    do_write(2'd1, 32'd255);
    do_write(2'd0, 32'd1);
    repeat (3) @(negedge clk);
    do_write(2'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    checks++;
    if (ledr0 !== '0 || ledr1 !== '0) begin
      errors++; $display("FAIL disable_ledr: got %h/%h, expected 0/0", ledr0, ledr1);
    end
    address = 2'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_a[i] !== exp_rd(i, address) || ledr_a[i] !== '0) begin
          errors++; $display("FAIL disable_running[%0d] @%0t: got rd %h ledr %h, expected rd %h ledr 0", i, $time, rd_a[i], ledr_a[i], exp_rd(i, address));
        end
      end
    end
    do_write(2'd3, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hABCD_EF5A);
    do_write(2'd2, 32'h1234_9876);
    for (int a = 0; a < 3; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (rd0 !== exp_vals[a] || rd1 !== exp_vals[a]) begin
        errors++; $display("FAIL readback_reg%0d: got %h/%h, expected %h", a, rd0, rd1, exp_vals[a]);
      end
    end
    address = 2'd3;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_a[i] !== exp_rd(i, address)) begin
        errors++; $display("FAIL readback_status[%0d]: got %h, expected %h", i, rd_a[i], exp_rd(i, address));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ledr_a[i] !== m_ledr[i]) begin
          errors++; $display("FAIL random_ledr[%0d] @%0t: got %h, expected %h", i, $time, ledr_a[i], m_ledr[i]);
        end
        checks++;
        if (rd_a[i] !== exp_rd(i, address)) begin
          errors++; $display("FAIL random_rd[%0d] a=%0d @%0t: got %h, expected %h", i, address, $time, rd_a[i], exp_rd(i, address));
        end
      end
      if ($urandom_range(0, 3) == 0) led_pattern = NL'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 7) == 0);
      write_n    = ($urandom_range(0, 1) == 1);
      case (address)
        2'd0:    writedata = {$urandom_range(0, 65535), 14'd0, 1'($urandom), ($urandom_range(0, 3) != 0)};
        2'd1:    writedata = $urandom;
        2'd2:    writedata = {16'($urandom), 16'($urandom_range(0, 2))};
        default: writedata = $urandom;
      endcase
    end
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rst_vals [4];
    bit lit = 0;
    rst_vals = '{32'h1, 32'hFF, 32'h0, 32'h1};
    led_pattern = 10'h3FF;
    do_write(2'd0, 32'd1);
    do_write(2'd1, 32'd10);
    for (int c = 0; c < 600 && !lit; c++) begin
      @(negedge clk);
      if (m_ledr[0] != '0 && m_ledr[1] != '0) lit = 1;
    end
    checks++;
    if (!lit || ledr0 === '0 || ledr1 === '0) begin
      errors++; $display("FAIL reset_mid_lit: got %h/%h, expected both lit", ledr0, ledr1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ledr0 !== '0 || ledr1 !== '0) begin
      errors++; $display("FAIL reset_mid_ledr: got %h/%h, expected 0/0", ledr0, ledr1);
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (rd0 !== rst_vals[a] || rd1 !== rst_vals[a]) begin
        errors++; $display("FAIL reset_mid_reg%0d: got %h/%h, expected %h", a, rd0, rd1, rst_vals[a]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd0[15:8] !== 8'd1 || rd1[15:8] !== 8'd0) begin
      errors++; $display("FAIL reset_mid_restart: got %h/%h, expected 01/00", rd0[15:8], rd1[15:8]);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ledr_a[i] !== m_ledr[i] || rd_a[i] !== exp_rd(i, address)) begin
          errors++; $display("FAIL reset_mid_follow[%0d] @%0t: got ledr %h rd %h, expected ledr %h rd %h", i, $time, ledr_a[i], rd_a[i], m_ledr[i], exp_rd(i, address));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_duty();
    test_duty();
    test_blink();
    test_period_frame_end();
    test_disable();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
